// File: rtl/regfile_pkg.sv
// Shared constants and types for the 16-bit datapath register file.
// Decode and execute import the same package.
package regfile_pkg;

  localparam int DATA_W   = 16;
  localparam int NUM_REGS = 16;
  localparam int ADDR_W   = $clog2(NUM_REGS);

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/reg_file_if.sv
// Operand/write bus between decode/execute and the register file.
// Handshake: none; reads are combinational and a write commits on the clock edge while wre=1.
interface reg_file_if #(
  parameter int DATA_W = regfile_pkg::DATA_W,
  parameter int ADDR_W = regfile_pkg::ADDR_W
);

  logic              wre;
  logic [ADDR_W-1:0] a1;
  logic [ADDR_W-1:0] a2;
  logic [ADDR_W-1:0] a3;
  logic [DATA_W-1:0] wd3;
  logic [DATA_W-1:0] rd1;
  logic [DATA_W-1:0] rd2;
  logic [DATA_W-1:0] rd3;

  modport master (
    output wre, a1, a2, a3, wd3,
    input  rd1, rd2, rd3
  );

  modport slave (
    input  wre, a1, a2, a3, wd3,
    output rd1, rd2, rd3
  );

endinterface

// File: rtl/regfile_rd_port.sv
// One combinational read port: register select plus, under
// REGFILE_WRITE_BYPASS_EN, a write-first forward of the pending write data.
module regfile_rd_port #(
  parameter int DATA_W   = regfile_pkg::DATA_W,
  parameter int NUM_REGS = regfile_pkg::NUM_REGS,
  parameter int ADDR_W   = regfile_pkg::ADDR_W
) (
  input  logic [NUM_REGS-1:0][DATA_W-1:0] regs,
  input  logic [ADDR_W-1:0]               addr,
`ifdef REGFILE_WRITE_BYPASS_EN
  input  logic                            byp_en,
  input  logic [ADDR_W-1:0]               wa,
  input  logic [DATA_W-1:0]               wd,
`endif
  output logic [DATA_W-1:0]               rd
);

  always_comb begin
    rd = regs[addr];
`ifdef REGFILE_WRITE_BYPASS_EN
    if (byp_en && (addr == wa)) begin
      rd = wd;
    end
`endif
  end

endmodule

// File: rtl/reg_file.sv
// 16x16 register file: three combinational read ports, one synchronous write
// port sharing its address with read port 3. Optional macro: REGFILE_WRITE_BYPASS_EN.
module reg_file #(
  parameter int DATA_W   = regfile_pkg::DATA_W,
  parameter int NUM_REGS = regfile_pkg::NUM_REGS,
  parameter int ADDR_W   = regfile_pkg::ADDR_W
) (
  input  logic       clk,
  input  logic       rst_n,
  reg_file_if.slave  bus
);

  typedef logic [NUM_REGS-1:0][DATA_W-1:0] bank_t;

  bank_t regs_q;
  bank_t regs_d;

  // Per-register enable: an unknown wre or a3 bit makes the compare unknown,
  // which the if treats as false, so no unaddressed register is disturbed.
  always_comb begin
    regs_d = regs_q;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (bus.wre && (bus.a3 == ADDR_W'(i))) begin
        regs_d[i] = bus.wd3;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  wre_known_a: assert property (@(posedge clk) disable iff (!rst_n) !$isunknown(bus.wre))
    else $error("reg_file: wre is unknown at clock edge");

`ifdef REGFILE_WRITE_BYPASS_EN
  logic byp_en;
  assign byp_en = bus.wre && rst_n;
`endif

  regfile_rd_port #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W)) u_rd1 (
    .regs   (regs_q),
    .addr   (bus.a1),
`ifdef REGFILE_WRITE_BYPASS_EN
    .byp_en (byp_en),
    .wa     (bus.a3),
    .wd     (bus.wd3),
`endif
    .rd     (bus.rd1)
  );

  regfile_rd_port #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W)) u_rd2 (
    .regs   (regs_q),
    .addr   (bus.a2),
`ifdef REGFILE_WRITE_BYPASS_EN
    .byp_en (byp_en),
    .wa     (bus.a3),
    .wd     (bus.wd3),
`endif
    .rd     (bus.rd2)
  );

  regfile_rd_port #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W)) u_rd3 (
    .regs   (regs_q),
    .addr   (bus.a3),
`ifdef REGFILE_WRITE_BYPASS_EN
    .byp_en (byp_en),
    .wa     (bus.a3),
    .wd     (bus.wd3),
`endif
    .rd     (bus.rd3)
  );

endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: array model checked every falling edge, plus
// literal expectations that pin the model.
module tb_reg_file;
  import regfile_pkg::*;

  logic clk;
  logic rst_n;

  reg_file_if bus ();

  reg_file dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: plain array of register contents
  word_t model [NUM_REGS];
  int    vectors     = 0;
  int    miscompares = 0;
  bit    cmp_en      = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) model[i] = '0;
    end else if (bus.wre === 1'b1) begin
      model[bus.a3] = bus.wd3;
    end
  end

  function automatic word_t exp_rd(reg_addr_t a);
`ifdef REGFILE_WRITE_BYPASS_EN
    if (rst_n === 1'b1 && bus.wre === 1'b1 && a == bus.a3) return bus.wd3;
`endif
    return model[a];
  endfunction

  task automatic check(string name, word_t got, word_t exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // Continuous compare against the model
  always @(negedge clk) begin
    if (cmp_en) begin
      check("model_rd1", bus.rd1, exp_rd(bus.a1));
      check("model_rd2", bus.rd2, exp_rd(bus.a2));
      check("model_rd3", bus.rd3, exp_rd(bus.a3));
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input reg_addr_t a, input word_t d);
    bus.wre = 1'b1;
    bus.a3  = a;
    bus.wd3 = d;
    tick();
    bus.wre = 1'b0;
  endtask

  task automatic set_reads(input reg_addr_t r1, input reg_addr_t r2, input reg_addr_t r3);
    bus.a1 = r1;
    bus.a2 = r2;
    bus.a3 = r3;
    #1;
  endtask

  initial begin
    rst_n   = 1'b0;
    bus.wre = 1'b0;
    bus.a1  = '0;
    bus.a2  = '0;
    bus.a3  = '0;
    bus.wd3 = '0;
    #12;
    check("reset_init_rd1", bus.rd1, 16'h0000);
    tick();
    rst_n  = 1'b1;
    cmp_en = 1'b1;

    // Preload the registers the reset test will clear
    write_reg(4'd11, 16'h1111);
    write_reg(4'd9,  16'h0909);
    write_reg(4'd7,  16'h0707);
    set_reads(4'd11, 4'd9, 4'd7);
    check("preload_rd1", bus.rd1, 16'h1111);
    check("preload_rd2", bus.rd2, 16'h0909);
    check("preload_rd3", bus.rd3, 16'h0707);

    // Mid-cycle asynchronous reset
    #1;
    rst_n = 1'b0;
    #1;
    check("reset_rd1", bus.rd1, 16'h0000);
    check("reset_rd2", bus.rd2, 16'h0000);
    check("reset_rd3", bus.rd3, 16'h0000);
    tick();
    rst_n = 1'b1;

    // Basic write
    write_reg(4'd7, 16'h0008);
    set_reads(4'd11, 4'd9, 4'd7);
    check("basic_rd3", bus.rd3, 16'h0008);
    check("basic_rd1", bus.rd1, 16'h0000);
    check("basic_rd2", bus.rd2, 16'h0000);

    // Write disabled
    bus.wre = 1'b0;
    bus.wd3 = 16'hFFFF;
    repeat (3) tick();
    check("wre0_rd3", bus.rd3, 16'h0008);

    // Same-cycle read and write of R7
    set_reads(4'd7, 4'd9, 4'd7);
    bus.wre = 1'b1;
    bus.wd3 = 16'h1234;
    #1;
`ifdef REGFILE_WRITE_BYPASS_EN
    check("same_cycle_rd1", bus.rd1, 16'h1234);
    check("same_cycle_rd3", bus.rd3, 16'h1234);
`else
    check("same_cycle_rd1", bus.rd1, 16'h0008);
    check("same_cycle_rd3", bus.rd3, 16'h0008);
`endif
    tick();
    bus.wre = 1'b0;
    #1;
    check("after_edge_rd1", bus.rd1, 16'h1234);

    // Every register, then read back on all three ports with rotated addresses
    for (int i = 0; i < NUM_REGS; i++) write_reg(reg_addr_t'(i), 16'hA500 + word_t'(i));
    for (int i = 0; i < NUM_REGS; i++) begin
      set_reads(reg_addr_t'(i), reg_addr_t'((i + 5) % NUM_REGS), reg_addr_t'((i + 11) % NUM_REGS));
      check("all_rd1", bus.rd1, 16'hA500 + word_t'(i));
      check("all_rd2", bus.rd2, 16'hA500 + word_t'((i + 5) % NUM_REGS));
      check("all_rd3", bus.rd3, 16'hA500 + word_t'((i + 11) % NUM_REGS));
    end

    // Back-to-back writes to one register: last one wins
    write_reg(4'd5, 16'h0001);
    write_reg(4'd5, 16'h0002);
    set_reads(4'd5, 4'd4, 4'd6);
    check("b2b_rd1", bus.rd1, 16'h0002);
    check("b2b_rd2", bus.rd2, 16'hA504);

    // Reset held across a write edge: the write is dropped
    bus.wre = 1'b1;
    bus.a3  = 4'd3;
    bus.wd3 = 16'h00FF;
    rst_n   = 1'b0;
    tick();
    rst_n   = 1'b1;
    bus.wre = 1'b0;
    set_reads(4'd3, 4'd3, 4'd3);
    check("rst_write_r3", bus.rd1, 16'h0000);

    // A few random writes checked by the model on each falling edge
    for (int i = 0; i < 12; i++) begin
      bus.a1 = reg_addr_t'($urandom_range(0, NUM_REGS - 1));
      bus.a2 = reg_addr_t'($urandom_range(0, NUM_REGS - 1));
      write_reg(reg_addr_t'($urandom_range(0, NUM_REGS - 1)), word_t'($urandom_range(0, 16'hFFFF)));
    end
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
